rr_arbiter_mux: RTL
===================

Name: rr_arbiter_mux

Overview:
- Parametrised round-robin arbiter and multiplexer. Merges NUM_CH input FIFO streams onto one output stream for the CDMA router.
- Work-conserving: it skips channels with no valid data instead of visiting a fixed slot sequence.
- Valid/ready handshake on both sides, with one registered output stage.
- Sits between the per-port input FIFOs and the router crossbar/encoder.

Parameters:
- NUM_CH, 4, number of input channels (2..16).
- DATA_W, 4, data width per channel.
- SEL_W, $clog2(NUM_CH), width of the channel index (derived; do not override).
- BURST_LEN, 4, maximum consecutive grants to one channel. Used only with RR_BURST_EN.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  NUM_CH  per-channel data available (FIFO not empty).
- req_data  in  NUM_CH*DATA_W  channel i occupies bits [i*DATA_W +: DATA_W].
- req_ready  out  NUM_CH  one-hot pop strobe to the granted FIFO (combinational).
- out_valid  out  1  out_data/out_sel hold a transfer.
- out_data  out  DATA_W  registered selected data.
- out_sel  out  SEL_W  registered index of the channel that sourced out_data.
- out_ready  in  1  downstream accepts when out_valid && out_ready.

Behaviour:
- Reset (async, rst=1):
  - out_valid=0, out_data=0, out_sel=0.
  - Priority pointer ptr=0; burst counter=0.
  - req_ready=0 while rst is asserted.
- Output stage has two states:
  - EMPTY: out_valid=0.
  - FULL: out_valid=1.
- load_en = (state==EMPTY) || out_ready.
- Grant pick (combinational):
  - g = first i with req_valid[i]=1, scanning ptr, ptr+1, ..., NUM_CH-1, 0, ..., ptr-1 (modulo NUM_CH).
  - any_req = |req_valid.
- Each cycle with load_en && any_req:
  - req_ready[g]=1, all other req_ready bits 0. The FIFO pops on this same edge.
  - Next edge: out_data<=req_data[g], out_sel<=g, state->FULL, ptr<=(g+1) mod NUM_CH.
- Each cycle with load_en && !any_req:
  - req_ready=0.
  - Next edge: state->EMPTY, out_valid<=0; out_data and out_sel hold their last value; ptr unchanged.
- Each cycle with !load_en (FULL and out_ready=0):
  - req_ready=0.
  - All registers hold. Output is stable under backpressure and no data is lost.
- Latency: 1 cycle from pop to out_valid. Sustains 1 transfer/cycle when out_ready=1 continuously.
- Wrap-around: ptr after channel NUM_CH-1 is 0.
- Fairness: with all channels valid, the grant order is 0, 1, ..., NUM_CH-1, 0, ...
  - A channel that drops valid is skipped with no idle slot.
  - No channel waits more than NUM_CH-1 grants while valid.
- Simultaneous drain and load in FULL with out_ready=1: the old word is consumed and the new word registered on the same edge.
- Reset mid-operation: the pending output word is discarded and ptr returns to 0. Input FIFOs are not popped during reset.
- req_ready is at most one-hot in every cycle. It is never asserted for a channel with req_valid=0.

Optional Feature:
- Macro: RR_BURST_EN.
- Defined:
  - A burst counter cnt (width $clog2(BURST_LEN+1)) is added.
  - After granting channel g, the next pick starts at g (ptr not advanced) while req_valid[g]=1 and cnt < BURST_LEN-1; cnt increments on each grant to g.
  - When g goes invalid or cnt reaches BURST_LEN-1: ptr<=(g+1) mod NUM_CH and cnt<=0.
  - Counter resets to 0 on rst and whenever a different channel is granted.
  - A backpressure stall does not change cnt.
- Undefined: pure single-grant round robin as above. BURST_LEN is ignored.

Decomposition:
- Package rr_arb_pkg:
  - Default NUM_CH and DATA_W constants.
  - Output-stage state typedef (EMPTY/FULL).
  - Function rr_pick(req, ptr) returning the index and a found flag.
- Sub-module rr_grant_pick:
  - Combinational rotating-priority encoder; req_valid and ptr in, g and any_req out.
  - Parametrised by NUM_CH.
  - Instantiated once; reusable by other router arbiters.

Test Plan:
- All 4 channels valid, data 0xA/0xB/0xC/0xD, out_ready=1 -> out_sel 0,1,2,3,0 on consecutive cycles; out_data A,B,C,D,A; req_ready one-hot 0001,0010,0100,1000.
- Only channels 1 and 3 valid, ptr=0 -> grants 1,3,1,3 with no idle cycles; req_ready[0] and req_ready[2] never assert.
- Channel 2 granted (out_sel=2, out_valid=1), out_ready held 0 for 5 cycles -> out_data/out_sel stable, req_ready=0 throughout; after out_ready=1, the next grant is 3.
- No requests -> out_valid falls one cycle after the last accepted transfer. Then req_valid[0] rises -> out_valid=1 next cycle with out_sel=0.
- Assert rst while out_valid=1 and ptr=2 -> out_valid=0 and out_data=0 immediately (async). After release with all channels valid, the first grant is channel 0.
- RR_BURST_EN, BURST_LEN=4, all channels valid -> out_sel 0,0,0,0,1,1,1,1,2... If channel 0 drops after 2 grants -> the next grant is 1.

Source files
------------

// File: rtl/rr_arb_pkg.sv
// Shared types and helpers for the router round-robin arbiters.
// Holds default sizing, the output-stage state type, and the
// rotating-priority pick function used by rr_grant_pick.
package rr_arb_pkg;

  localparam int RR_NUM_CH   = 4;
  localparam int RR_DATA_W   = 4;
  // Largest channel count the pick function supports.
  localparam int RR_MAX_CH   = 16;
  localparam int RR_MAX_SELW = 4;

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} ostate_t;

  typedef struct packed {
    logic                   found;
    logic [RR_MAX_SELW-1:0] idx;
  } pick_t;

  // First set bit of req[n-1:0], scanning from ptr upward with wrap.
  // The scan runs backwards so the last hit written is the nearest
  // to ptr, which avoids a break and keeps the loop bound constant.
  function automatic pick_t rr_pick(input logic [RR_MAX_CH-1:0]   req,
                                    input logic [RR_MAX_SELW-1:0] ptr,
                                    input int                     n);
    pick_t r;
    int    idx;
    r = '0;
    for (int k = RR_MAX_CH - 1; k >= 0; k--) begin
      if (k < n) begin
        idx = int'(ptr) + k;
        if (idx >= n) idx = idx - n;
        if (req[idx[RR_MAX_SELW-1:0]]) begin
          r.found = 1'b1;
          r.idx   = idx[RR_MAX_SELW-1:0];
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/rr_grant_pick.sv
// Combinational rotating-priority encoder: picks the first valid
// channel at or after ptr, wrapping at NUM_CH.
module rr_grant_pick
  import rr_arb_pkg::*;
#(
  parameter int NUM_CH = RR_NUM_CH,
  parameter int SEL_W  = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req_valid,
  input  logic [SEL_W-1:0]  ptr,
  output logic [SEL_W-1:0]  g,
  output logic              any_req
);

  pick_t p;

  // Widen to the package's fixed size, pick, then narrow back.
  always_comb begin
    p       = rr_pick(RR_MAX_CH'(req_valid), RR_MAX_SELW'(ptr), NUM_CH);
    g       = SEL_W'(p.idx);
    any_req = p.found;
  end

endmodule

// File: rtl/rr_arbiter_mux.sv
// Round-robin arbiter + mux merging NUM_CH FIFO streams into one
// registered valid/ready output for the CDMA router.
// Build option: define RR_BURST_EN to let a granted channel keep
// priority for up to BURST_LEN consecutive grants.
module rr_arbiter_mux
  import rr_arb_pkg::*;
#(
  parameter int NUM_CH    = RR_NUM_CH,
  parameter int DATA_W    = RR_DATA_W,
  parameter int SEL_W     = $clog2(NUM_CH),
  parameter int BURST_LEN = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_CH-1:0]        req_valid,
  input  logic [NUM_CH*DATA_W-1:0] req_data,
  output logic [NUM_CH-1:0]        req_ready,
  output logic                     out_valid,
  output logic [DATA_W-1:0]        out_data,
  output logic [SEL_W-1:0]         out_sel,
  input  logic                     out_ready
);

  // Out-of-range sizing leaves an empty, named marker block behind.
  if (NUM_CH < 2 || NUM_CH > RR_MAX_CH || BURST_LEN < 1) begin : g_bad_params
  end

  ostate_t                       state;
  logic [SEL_W-1:0]              ptr;
  logic [SEL_W-1:0]              g;
  logic [SEL_W-1:0]              g_nxt;
  logic                          any_req;
  logic                          load_en;
  logic                          grant;
  logic [NUM_CH-1:0][DATA_W-1:0] ch_data;

  assign ch_data = req_data;

  rr_grant_pick #(.NUM_CH(NUM_CH), .SEL_W(SEL_W)) u_pick (
    .req_valid (req_valid),
    .ptr       (ptr),
    .g         (g),
    .any_req   (any_req)
  );

  assign load_en   = (state == EMPTY) || out_ready;
  assign grant     = load_en && any_req && !rst;
  assign g_nxt     = (g == SEL_W'(NUM_CH - 1)) ? '0 : g + 1'b1;
  assign out_valid = (state == FULL);

  // One-hot pop to the granted FIFO, same cycle as the load.
  assign req_ready = grant ? (NUM_CH'(1) << g) : '0;

`ifdef RR_BURST_EN
  localparam int CNT_W = $clog2(BURST_LEN + 1);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_base;
  logic             stay;

  // A grant to a channel other than the held one restarts the count.
  assign cnt_base = (g == ptr) ? cnt : '0;
  assign stay     = cnt_base < CNT_W'(BURST_LEN - 1);

  // Output stage plus pointer/burst tracking; stalls hold everything.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= EMPTY;
      out_data <= '0;
      out_sel  <= '0;
      ptr      <= '0;
      cnt      <= '0;
    end else if (load_en) begin
      if (any_req) begin
        state    <= FULL;
        out_data <= ch_data[g];
        out_sel  <= g;
        if (stay) begin
          ptr <= g;
          cnt <= cnt_base + 1'b1;
        end else begin
          ptr <= g_nxt;
          cnt <= '0;
        end
      end else begin
        state <= EMPTY;
      end
    end
  end
`else
  // Output stage plus pointer; stalls hold everything.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= EMPTY;
      out_data <= '0;
      out_sel  <= '0;
      ptr      <= '0;
    end else if (load_en) begin
      if (any_req) begin
        state    <= FULL;
        out_data <= ch_data[g];
        out_sel  <= g;
        ptr      <= g_nxt;
      end else begin
        state <= EMPTY;
      end
    end
  end
`endif

endmodule
